axi4_lite_regfile: RTL

Parametrised AXI4-Lite slave register bank: NUM_REGS software-visible registers of DATA_WIDTH bits, byte-strobed writes, per-register read-only (hardware-sourced) selection, SLVERR on illegal accesses, and per-register access pulses toward the datapath. It sits behind the ifc_axi4_lite slave modport as the standard control/status endpoint of every block. It supersedes single-register ad-hoc slaves.

---
 rtl/axi4_lite_regfile_if.sv | 35 +++
 rtl/axi4_lite_regfile.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_regfile_if.sv
// AXI4-Lite channel bundle shared by register-bank masters and slaves.
interface ifc_axi4_lite #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                      awvalid;
  logic                      awready;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic [2:0]                awprot;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic [2:0]                arprot;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite register bank: byte-strobed RW registers, hardware-sourced RO registers,
// SLVERR on illegal accesses, and one-cycle access pulses toward the datapath.
module axi4_lite_regfile #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  ifc_axi4_lite.slave                    s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_i,
  output logic [NUM_REGS-1:0]            wr_pulse_o,
  output logic [NUM_REGS-1:0]            rd_pulse_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned SHIFT  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
    $error("axi4_lite_regfile: DATA_WIDTH must be 32 or 64");
  end
  if (NUM_REGS < 1) begin : g_bad_count
    $error("axi4_lite_regfile: NUM_REGS must be at least 1");
  end
  if (BASE_ADDR[SHIFT-1:0] != '0) begin : g_bad_base
    $error("axi4_lite_regfile: BASE_ADDR must be aligned to DATA_WIDTH/8");
  end

  typedef enum logic {W_COLLECT, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = (addr - BASE_ADDR) >> SHIFT;
    return off[IDX_W-1:0];
  endfunction

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = (addr - BASE_ADDR) >> SHIFT;
    return (addr >= BASE_ADDR) && (off < ADDR_WIDTH'(NUM_REGS));
  endfunction

  w_state_e              w_state_q, w_state_d;
  r_state_e              r_state_q, r_state_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d, rd_pulse_q, rd_pulse_d;

  logic                  aw_hs, w_hs, wr_ok, wr_hit, rd_ok;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  unused_prot;

  assign unused_prot = ^{s_axi.awprot, s_axi.arprot};

  always_comb begin
    w_state_d  = w_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
    wr_idx     = '0;
    wr_ok      = 1'b0;
    wr_hit     = 1'b0;
    aw_hs      = s_axi.awvalid && awready_q;
    w_hs       = s_axi.wvalid && wready_q;
    case (w_state_q)
      W_COLLECT: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axi.awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi.wdata;
          wstrb_d  = s_axi.wstrb;
        end
        // Commit uses the _d view so a half arriving this cycle is included.
        if (aw_held_d && w_held_d) begin
          wr_idx = addr_idx(awaddr_d);
          wr_ok  = addr_ok(awaddr_d);
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (wr_ok && !RO_MASK[i] && wr_idx == IDX_W'(i)) begin
              wr_hit        = 1'b1;
              wr_pulse_d[i] = 1'b1;
              for (int unsigned k = 0; k < STRB_W; k++) begin
                if (wstrb_d[k]) regs_d[i][8*k +: 8] = wdata_d[8*k +: 8];
              end
            end
          end
          bresp_d   = wr_hit ? 2'b00 : 2'b10;
          bvalid_d  = 1'b1;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          w_state_d = W_RESP;
        end else begin
          awready_d = !aw_held_d;
          wready_d  = !w_held_d;
        end
      end
      W_RESP: begin
        if (s_axi.bready) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_COLLECT;
        end
      end
      default: w_state_d = W_COLLECT;
    endcase
  end

  // Reads sample regs_q, so a same-cycle write commit is not visible to the read.
  always_comb begin
    r_state_d  = r_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_pulse_d = '0;
    rd_idx     = '0;
    rd_ok      = 1'b0;
    rd_val     = '0;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (s_axi.arvalid && arready_q) begin
          rd_idx = addr_idx(s_axi.araddr);
          rd_ok  = addr_ok(s_axi.araddr);
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_ok && rd_idx == IDX_W'(i)) begin
              rd_val        = RO_MASK[i] ? reg_i[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
              rd_pulse_d[i] = 1'b1;
            end
          end
          rdata_d   = rd_val;
          rresp_d   = rd_ok ? 2'b00 : 2'b10;
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (s_axi.rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q  <= W_COLLECT;
      r_state_q  <= R_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      regs_q     <= '{default: '0};
      wr_pulse_q <= '0;
      rd_pulse_q <= '0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      rd_pulse_q <= rd_pulse_d;
    end
  end

  always_comb begin
    reg_o = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_o[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs_q[i];
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign wr_pulse_o    = wr_pulse_q;
  assign rd_pulse_o    = rd_pulse_q;

endmodule
